// File: rtl/nonogram_stream_parser.sv
// Nonogram clue-stream parser: 2-byte tokens from the UART in, clue BRAM writes out.
// Row addresses are accumulated (row_base += stride) so no multiplier is needed.
module nonogram_stream_parser #(
  parameter int DIM_W    = 12,
  parameter int MAX_DIM  = 4095,
  parameter int DATA_W   = 13,
  parameter int ADDR_W   = 26,
  parameter int MAX_ROWS = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DIM_W-1:0]  n,
  output logic [DIM_W-1:0]  m,
  output logic              board_done,
  output logic              err,
  output logic [2:0]        err_code
);
  localparam int ROW_W = $clog2(MAX_ROWS + 1);
  localparam int COL_W = DIM_W + 1;

  localparam logic [2:0] FL_START_BOARD = 3'b111;
  localparam logic [2:0] FL_END_BOARD   = 3'b000;
  localparam logic [2:0] FL_START_LINE  = 3'b110;
  localparam logic [2:0] FL_END_LINE    = 3'b001;
  localparam logic [2:0] FL_AND         = 3'b101;
  localparam logic [2:0] FL_OR          = 3'b010;

  typedef enum logic [1:0] {IDLE, HDR_M, BODY} state_t;
  state_t state, state_nx;

  logic              phase, run, accept, tok_fire;
  logic [7:0]        byte0;
  logic [2:0]        flag;
  logic [12:0]       payload;
  logic [DIM_W-1:0]  pay_dim, n_nx, m_nx;
  logic [COL_W-1:0]  stride, stride_nx, col, col_nx;
  logic [ROW_W-1:0]  row, row_nx, line_idx, li_nx;
  logic [ADDR_W-1:0] row_base, row_base_nx, wr_addr_nx;
  logic [DATA_W-1:0] wr_data_nx;
  logic              wr_set, done_nx, err_nx;
  logic [2:0]        err_code_nx;

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (32'(d) > MAX_DIM);
  endfunction

  function automatic logic [COL_W-1:0] stride_of(input logic [DIM_W-1:0] a,
                                                 input logic [DIM_W-1:0] b);
    return (a > b) ? ({1'b0, a} + COL_W'(1)) : ({1'b0, b} + COL_W'(1));
  endfunction

  // No byte is taken while a write is outstanding; held low during and right after reset.
  assign ready_out = run && !wr_valid;
  assign accept    = valid_in && ready_out;
  assign tok_fire  = accept && phase;
  assign flag      = byte0[7:5];
  assign payload   = {byte0[4:0], byte_in};
  assign pay_dim   = payload[DIM_W-1:0];

  always_comb begin
    state_nx    = state;
    n_nx        = n;
    m_nx        = m;
    stride_nx   = stride;
    row_nx      = row;
    row_base_nx = row_base;
    col_nx      = col;
    li_nx       = line_idx;
    wr_set      = 1'b0;
    wr_addr_nx  = wr_addr;
    wr_data_nx  = wr_data;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    err_code_nx = 3'd0;
    if (tok_fire) begin
      case (state)
        IDLE: begin
          if (flag == FL_START_BOARD) begin
            n_nx     = pay_dim;
            state_nx = HDR_M;
          end
        end
        HDR_M: begin
          state_nx = IDLE;
          if (flag != FL_START_BOARD) begin
            err_nx      = 1'b1;
            err_code_nx = 3'd1;
          end else begin
            m_nx        = pay_dim;
            stride_nx   = stride_of(n, pay_dim);
            row_nx      = '0;
            row_base_nx = '0;
            col_nx      = '0;
            li_nx       = '0;
            if (dim_bad(n) || dim_bad(pay_dim)) begin
              err_nx      = 1'b1;
              err_code_nx = 3'd2;
            end else begin
              state_nx = BODY;
            end
          end
        end
        BODY: begin
          case (flag)
            FL_START_BOARD: begin
              n_nx     = pay_dim;
              state_nx = HDR_M;
            end
            FL_START_LINE: begin
              wr_set     = 1'b1;
              wr_addr_nx = row_base;
              wr_data_nx = DATA_W'(line_idx);
              col_nx     = COL_W'(1);
            end
            FL_AND: begin
              if (col == stride) begin
                err_nx      = 1'b1;
                err_code_nx = 3'd5;
                state_nx    = IDLE;
              end else begin
                wr_set     = 1'b1;
                wr_addr_nx = row_base + ADDR_W'(col);
                wr_data_nx = DATA_W'(payload);
                col_nx     = col + COL_W'(1);
              end
            end
            FL_OR, FL_END_LINE: begin
              if (32'(row) == MAX_ROWS) begin
                err_nx      = 1'b1;
                err_code_nx = 3'd6;
                state_nx    = IDLE;
              end else begin
                row_nx      = row + ROW_W'(1);
                row_base_nx = row_base + ADDR_W'(stride);
                if (flag == FL_OR) begin
                  // OR continues the same line on a fresh row, tagged with the current line index
                  wr_set     = 1'b1;
                  wr_addr_nx = row_base_nx;
                  wr_data_nx = DATA_W'(line_idx);
                  col_nx     = COL_W'(1);
                end else begin
                  col_nx = '0;
                  li_nx  = line_idx + ROW_W'(1);
                end
              end
            end
            FL_END_BOARD: begin
              state_nx = IDLE;
              if (line_idx == (ROW_W'(n) + ROW_W'(m))) begin
                done_nx = 1'b1;
              end else begin
                err_nx      = 1'b1;
                err_code_nx = 3'd4;
              end
            end
            default: begin
              err_nx      = 1'b1;
              err_code_nx = 3'd3;
              state_nx    = IDLE;
            end
          endcase
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run        <= 1'b0;
      phase      <= 1'b0;
      byte0      <= '0;
      n          <= '0;
      m          <= '0;
      stride     <= '0;
      row        <= '0;
      row_base   <= '0;
      col        <= '0;
      line_idx   <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      board_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= 3'd0;
    end else begin
      state      <= state_nx;
      run        <= 1'b1;
      if (accept) begin
        phase <= !phase;
        if (!phase) byte0 <= byte_in;
      end
      n          <= n_nx;
      m          <= m_nx;
      stride     <= stride_nx;
      row        <= row_nx;
      row_base   <= row_base_nx;
      col        <= col_nx;
      line_idx   <= li_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
      if (wr_set) wr_valid <= 1'b1;
      else if (wr_ready) wr_valid <= 1'b0;
      board_done <= done_nx;
      err        <= err_nx;
      err_code   <= err_code_nx;
    end
  end
endmodule

// File: tb/tb_nonogram_stream_parser.sv
// Bench for nonogram_stream_parser: directed clue streams plus randomized boards
// against a token-level reference model with a per-cycle output compare.
module tb_nonogram_stream_parser;
  localparam int DIM_W    = 12;
  localparam int DATA_W   = 13;
  localparam int ADDR_W   = 26;
  localparam int MAX_ROWS = 65535;

  localparam int A22 [8] = '{0, 1, 3, 4, 6, 7, 9, 10};
  localparam int D22 [8] = '{0, 1, 1, 2, 2, 1, 3, 1};
  localparam int AOR [8] = '{0, 1, 4, 5, 0, 0, 0, 0};
  localparam int DOR [8] = '{0, 5, 0, 7, 0, 0, 0, 0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DIM_W-1:0]  n, m;
  logic              board_done, err;
  logic [2:0]        err_code;

  always #5 clk = ~clk;

  nonogram_stream_parser dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .valid_in(valid_in),
    .ready_out(ready_out), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .n(n), .m(m),
    .board_done(board_done), .err(err), .err_code(err_code)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (token level) ----------------
  int        ms, mph, mn, mm, mstride, mrow, mcol, mli, m_code;
  logic [7:0] mb0;
  time       t_err, t_done;
  int        q_addr[$], q_data[$], log_a[$], log_d[$];

  task automatic model_reset();
    ms = 0; mph = 0; mn = 0; mm = 0; mstride = 0; mrow = 0; mcol = 0; mli = 0;
    m_code = 0; mb0 = 8'h00; t_err = '1; t_done = '1;
    q_addr.delete(); q_data.delete();
  endtask

  task automatic mwr(input int a, input int d);
    q_addr.push_back(a & ((1 << ADDR_W) - 1));
    q_data.push_back(d & ((1 << DATA_W) - 1));
    log_a.push_back(a & ((1 << ADDR_W) - 1));
    log_d.push_back(d & ((1 << DATA_W) - 1));
  endtask

  task automatic merr(input int code);
    t_err = $time; m_code = code; ms = 0;
  endtask

  // Called at the clock edge on which byte b is accepted.
  task automatic model_feed(input logic [7:0] b);
    logic [2:0] fl;
    int pl, pd;
    if (mph == 0) begin
      mb0 = b; mph = 1;
      return;
    end
    mph = 0;
    fl = mb0[7:5];
    pl = int'({mb0[4:0], b});
    pd = pl & 'hFFF;
    case (ms)
      0: if (fl == 3'b111) begin mn = pd; ms = 1; end
      1: begin
        if (fl != 3'b111) merr(1);
        else begin
          mm = pd; mstride = ((mn > mm) ? mn : mm) + 1;
          mrow = 0; mcol = 0; mli = 0;
          if (mn == 0 || mm == 0) merr(2); else ms = 2;
        end
      end
      default: begin
        case (fl)
          3'b111: begin mn = pd; ms = 1; end
          3'b110: begin mwr(mrow * mstride, mli); mcol = 1; end
          3'b101: begin
            if (mcol == mstride) merr(5);
            else begin mwr(mrow * mstride + mcol, pl); mcol++; end
          end
          3'b010: begin
            if (mrow == MAX_ROWS) merr(6);
            else begin mrow++; mwr(mrow * mstride, mli); mcol = 1; end
          end
          3'b001: begin
            if (mrow == MAX_ROWS) merr(6);
            else begin mrow++; mcol = 0; mli++; end
          end
          3'b000: begin
            if (mli == mn + mm) t_done = $time; else merr(4);
            ms = 0;
          end
          default: merr(3);
        endcase
      end
    endcase
  endtask

  // ---------------- per-cycle compare ----------------
  logic prev_rst = 1'b0;
  int   dut_wr_cnt = 0, dut_done_cnt = 0, dut_err_cnt = 0;
  logic [2:0] dut_last_code = 3'd0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_wr_outputs", {wr_valid, wr_addr, wr_data}, 64'd0);
      chk("rst_ctl_outputs", {ready_out, n, m, board_done, err, err_code}, 64'd0);
    end else begin
      if (prev_rst) chk("ready_out", ready_out, !wr_valid);
      chk("n", n, mn);
      chk("m", m, mm);
      chk("board_done", board_done, t_done == $time - 5);
      chk("err", err, t_err == $time - 5);
      if (err === 1'b1) begin
        chk("err_code", err_code, m_code);
        dut_last_code = err_code;
        dut_err_cnt++;
      end
      if (board_done === 1'b1) dut_done_cnt++;
      if (wr_valid === 1'b1) begin
        if (q_addr.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected: addr %0d data %0d, no write expected", wr_addr, wr_data);
        end else begin
          chk("wr_addr", wr_addr, q_addr[0]);
          chk("wr_data", wr_data, q_data[0]);
          if (wr_ready === 1'b1) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
            dut_wr_cnt++;
          end
        end
      end
    end
    prev_rst = rst_n;
  end

  // ---------------- write-side backpressure ----------------
  int rmode = 0;
  int stall = 0;
  initial forever begin
    @(posedge clk);
    #2;
    case (rmode)
      0: wr_ready = 1'b1;
      1: begin
        if (wr_valid && stall >= 5) begin wr_ready = 1'b1; stall = 0; end
        else begin wr_ready = 1'b0; if (wr_valid) stall++; end
      end
      default: wr_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- stimulus ----------------
  logic [7:0] stim[$];

  task automatic push2(input logic [7:0] b0, input logic [7:0] b1);
    stim.push_back(b0); stim.push_back(b1);
  endtask

  task automatic push_tok(input logic [2:0] fl, input logic [12:0] p);
    stim.push_back({fl, p[12:8]}); stim.push_back(p[7:0]);
  endtask

  task automatic add_2x2();
    push2(8'hE0, 8'h02); push2(8'hE0, 8'h02);
    push2(8'hC0, 8'h00); push2(8'hA0, 8'h01); push2(8'h20, 8'h00);
    push2(8'hC0, 8'h00); push2(8'hA0, 8'h02); push2(8'h20, 8'h00);
    push2(8'hC0, 8'h00); push2(8'hA0, 8'h01); push2(8'h20, 8'h00);
    push2(8'hC0, 8'h00); push2(8'hA0, 8'h01); push2(8'h20, 8'h00);
    push2(8'h00, 8'h00);
  endtask

  // Entered and left at posedge+2.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waitc;
    logic r;
    waitc = 0;
    byte_in = b; valid_in = 1'b1;
    forever begin
      r = ready_out;
      @(posedge clk);
      if (r) break;
      waitc++;
      if (waitc > 300) begin
        checks++; failures++;
        $display("FAIL accept_timeout: byte %0h not accepted in 300 cycles", b);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      #2;
    end
    model_feed(b);
    #2;
    valid_in = 1'b0;
    repeat (gap) begin @(posedge clk); #2; end
  endtask

  task automatic send_stim(input int gapmax);
    while (stim.size() != 0) send_byte(stim.pop_front(), $urandom_range(0, gapmax));
  endtask

  task automatic settle();
    int c;
    c = 0;
    while ((wr_valid === 1'b1 || q_addr.size() != 0) && c < 1000) begin
      @(posedge clk); c++;
    end
    repeat (3) @(posedge clk);
    #2;
    if (c >= 1000) begin
      checks++; failures++;
      $display("FAIL settle_timeout: %0d writes still pending", q_addr.size());
    end
  endtask

  task automatic check_log(input string tag, input int ea[8], input int ed[8], input int cnt);
    chk($sformatf("%s_len", tag), log_a.size(), cnt);
    for (int i = 0; i < cnt && i < log_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), log_a[i], ea[i]);
      chk($sformatf("%s_data%0d", tag, i), log_d[i], ed[i]);
    end
  endtask

  task automatic gen_random_board();
    int nn, mm2, st, lines, k;
    repeat ($urandom_range(0, 2)) push_tok(3'($urandom_range(0, 6)), 13'($urandom));
    nn  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
    mm2 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
    push_tok(3'b111, 13'(nn));
    if ($urandom_range(0, 11) == 0) push_tok(3'b110, 13'd0);
    else push_tok(3'b111, 13'(mm2));
    st = ((nn > mm2) ? nn : mm2) + 1;
    lines = nn + mm2;
    if ($urandom_range(0, 5) == 0) lines += ($urandom_range(0, 1) != 0) ? 1 : -1;
    for (int l = 0; l < lines; l++) begin
      push_tok(3'b110, 13'($urandom));
      k = ($urandom_range(0, 9) == 0) ? st : int'($urandom_range(0, st - 1));
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 7) == 0) push_tok(3'b010, 13'($urandom));
        else push_tok(3'b101, 13'($urandom));
      end
      if ($urandom_range(0, 29) == 0) push_tok(($urandom_range(0, 1) != 0) ? 3'b011 : 3'b100, 13'd0);
      push_tok(3'b001, 13'($urandom));
    end
    push_tok(3'b000, 13'($urandom));
  endtask

  int base_done, base_err, base_wr;
  task automatic mark();
    log_a.delete(); log_d.delete();
    base_done = dut_done_cnt; base_err = dut_err_cnt; base_wr = dut_wr_cnt;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ready_out", ready_out, 1'b0);
    chk("reset_wr_valid", wr_valid, 1'b0);
    rst_n = 1'b1;

    // Legal 2x2 board
    rmode = 0; mark();
    add_2x2(); send_stim(0); settle();
    check_log("b22", A22, D22, 8);
    chk("b22_done", dut_done_cnt - base_done, 1);
    chk("b22_err", dut_err_cnt - base_err, 0);
    chk("b22_wr", dut_wr_cnt - base_wr, 8);
    chk("b22_n", n, 2);
    chk("b22_m", m, 2);

    // OR clause, n=1 m=3
    mark();
    push2(8'hE0, 8'h01); push2(8'hE0, 8'h03); push2(8'hC0, 8'h00);
    push2(8'hA0, 8'h05); push2(8'h40, 8'h00); push2(8'hA0, 8'h07);
    send_stim(0); settle();
    check_log("or", AOR, DOR, 4);
    chk("or_wr", dut_wr_cnt - base_wr, 4);
    chk("or_m", m, 3);

    // Backpressure: 5 stalled cycles per write; also aborts the open OR board
    rmode = 1; mark();
    add_2x2(); send_stim(0); settle();
    check_log("bp", A22, D22, 8);
    chk("bp_done", dut_done_cnt - base_done, 1);
    chk("bp_err", dut_err_cnt - base_err, 0);
    chk("bp_wr", dut_wr_cnt - base_wr, 8);
    rmode = 0;

    // Error causes
    mark();
    push2(8'hE0, 8'h00); push2(8'hE0, 8'h02); send_stim(0); settle();
    chk("e2_code", dut_last_code, 2);
    chk("e2_cnt", dut_err_cnt - base_err, 1);
    mark();
    push2(8'hE0, 8'h02); push2(8'hE0, 8'h02); push2(8'h60, 8'h00); send_stim(0); settle();
    chk("e3_code", dut_last_code, 3);
    mark();
    push2(8'hE0, 8'h02); push2(8'hE0, 8'h02);
    push2(8'hC0, 8'h00); push2(8'hA0, 8'h01); push2(8'h20, 8'h00);
    push2(8'hC0, 8'h00); push2(8'hA0, 8'h02); push2(8'h20, 8'h00);
    push2(8'h00, 8'h00); send_stim(0); settle();
    chk("e4_code", dut_last_code, 4);
    chk("e4_done", dut_done_cnt - base_done, 0);
    mark();
    push2(8'hE0, 8'h02); push2(8'hE0, 8'h02); push2(8'hC0, 8'h00);
    repeat (4) push2(8'hA0, 8'h01);
    send_stim(0); settle();
    chk("e5_code", dut_last_code, 5);
    chk("e5_wr", dut_wr_cnt - base_wr, 3);
    mark();
    push2(8'hE0, 8'h01); push2(8'hC0, 8'h00); send_stim(0); settle();
    chk("e1_code", dut_last_code, 1);

    // Resync: junk in IDLE, then a good board
    mark();
    push2(8'hA0, 8'h01); push2(8'h20, 8'h00); add_2x2(); send_stim(0); settle();
    check_log("rs", A22, D22, 8);
    chk("rs_err", dut_err_cnt - base_err, 0);
    chk("rs_done", dut_done_cnt - base_done, 1);

    // Async reset between byte0 and byte1
    send_byte(8'hE0, 0);
    rst_n = 1'b0;
    #1;
    chk("areset_wr", {wr_valid, wr_addr, wr_data}, 64'd0);
    chk("areset_ctl", {ready_out, n, m, board_done, err, err_code}, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    mark();
    add_2x2(); send_stim(0); settle();
    check_log("ar", A22, D22, 8);
    chk("ar_done", dut_done_cnt - base_done, 1);
    chk("ar_err", dut_err_cnt - base_err, 0);

    // Randomized boards with random backpressure and byte gaps
    rmode = 2;
    repeat (40) begin
      gen_random_board();
      send_stim(1);
    end
    settle();
    chk("final_queue_empty", q_addr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
